// File: rtl/ram8_burst_master.sv
// Burst initiator for the 8-word RAM port: one start command becomes a
// sequence of single-word RAM accesses with valid/ready streams on the data side.
//
// Ports:
//   clk, reset            clock and async active-high reset
//   start/dir/base/count  burst command (captured in IDLE)
//   busy, done            status (done is a one-cycle pulse)
//   wr_data/valid/ready   write stream into the RAM
//   rd_data/valid/ready   read stream out of the RAM (rd_data registered)
//   mem_addr/wdata/load   RAM pins; mem_rdata is its combinational read data
module ram8_burst_master #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      count,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_load,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WRITE,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   ptr;
  logic [AW:0]     remaining;
  logic            dir_q;
  logic            last;

  assign last = (remaining == {{AW{1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      dir_q     <= 1'b0;
      rd_data   <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start && count != '0) begin
            ptr       <= base;
            remaining <= count;
            dir_q     <= dir;
          end
        end
        FETCH: rd_data <= mem_rdata;
        SEND: begin
          if (rd_ready) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        WRITE: begin
          if (wr_valid) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    mem_wdata = '0;
    mem_load  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (count == '0) state_nx = DONE;
          else if (dir)    state_nx = WRITE;
          else             state_nx = FETCH;
        end
      end
      FETCH: state_nx = SEND;
      SEND: begin
        rd_valid = 1'b1;
        if (rd_ready) state_nx = last ? DONE : FETCH;
      end
      WRITE: begin
        wr_ready  = 1'b1;
        mem_wdata = wr_data;
        // gated by reset so an assert between edges blocks the RAM write
        mem_load  = wr_valid & ~reset;
        if (wr_valid && last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_addr = ptr;

endmodule

// File: tb/tb_ram8_burst_master.sv
// Bench for ram8_burst_master: RAM model, directed bursts, and a
// scoreboard monitor checking stream and RAM write traffic.
module tb_ram8_burst_master;

  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic        dir = 0;
  logic [2:0]  base = 0;
  logic [3:0]  count = 0;
  logic        busy, done;
  logic [15:0] wr_data = 0;
  logic        wr_valid = 0;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready = 0;
  logic [2:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_load;
  logic [15:0] mem_rdata;

  logic [15:0] ram [8];
  logic [15:0] rq [$];
  logic [18:0] wq [$];
  int          tests = 0;
  int          fails = 0;
  logic        stall_q = 0;
  logic [15:0] held_q = 0;

  always #5 clk = ~clk;

  ram8_burst_master dut (
    .clk(clk), .reset(reset), .start(start), .dir(dir),
    .base(base), .count(count), .busy(busy), .done(done),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_load(mem_load), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (mem_load) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (stall_q)
        chk(rd_valid && rd_data == held_q, "rd_hold",
            {15'd0, rd_valid, rd_data}, {16'd1, held_q});
      if (rd_valid && rd_ready) begin
        if (rq.size() == 0)
          chk(0, "rd_unexpected", {16'd0, rd_data}, 0);
        else begin
          logic [15:0] e;
          e = rq.pop_front();
          chk(rd_data == e, "rd_data", {16'd0, rd_data}, {16'd0, e});
        end
      end
      if (mem_load) begin
        if (wq.size() == 0)
          chk(0, "wr_unexpected", {13'd0, mem_addr, mem_wdata}, 0);
        else begin
          logic [18:0] e;
          e = wq.pop_front();
          chk({mem_addr, mem_wdata} == e, "ram_write",
              {13'd0, mem_addr, mem_wdata}, {13'd0, e});
        end
      end
      stall_q <= rd_valid && !rd_ready;
      held_q  <= rd_data;
    end else begin
      stall_q <= 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [2:0] b, input logic [3:0] n,
                          input logic [15:0] d0);
    for (int i = 0; i < n; i++)
      wq.push_back({b + 3'(i), d0 + 16'(i)});
    dir = 1; base = b; count = n; start = 1;
    cyc();
    start = 0;
    wr_valid = 1;
    wr_data = d0;
    for (int i = 0; i < n; i++) begin
      cyc();
      wr_data = d0 + 16'(i + 1);
    end
    chk(done === 1'b1, "wr_done", {31'd0, done}, 1);
    wr_valid = 0;
    cyc();
    chk(busy === 1'b0 && done === 1'b0, "wr_idle",
        {30'd0, busy, done}, 0);
    chk(wq.size() == 0, "wr_q_empty", wq.size(), 0);
  endtask

  task automatic do_read(input logic [2:0] b, input logic [3:0] n,
                         input bit toggle, input bit poke);
    bit seen;
    seen = 0;
    dir = 0; base = b; count = n; start = 1;
    cyc();
    start = 0;
    rd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (poke && i == 1) begin
        start = 1; dir = 1; count = 2;
      end else begin
        start = 0;
      end
      cyc();
      if (toggle) rd_ready = ~rd_ready;
    end
    start = 0;
    chk(seen, "rd_done_timeout", {31'd0, seen}, 1);
    rd_ready = 0;
    cyc();
    chk(busy === 1'b0, "rd_idle", {31'd0, busy}, 0);
    chk(rq.size() == 0, "rd_q_empty", rq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = 16'h1000 + 16'(i);
    #2;
    chk({busy, done, rd_valid, wr_ready, mem_load, mem_addr,
         mem_wdata, rd_data} == '0, "reset_outputs",
        {busy, done, rd_valid, wr_ready, mem_load, mem_addr}, 0);
    cyc(); cyc();
    reset = 0;
    cyc();

    // reset during a write cycle
    dir = 1; base = 2; count = 2; start = 1;
    cyc();
    start = 0;
    chk(wr_ready === 1'b1, "wr_ready_on", {31'd0, wr_ready}, 1);
    wr_data = 16'hDEAD;
    wr_valid = 1;
    #1 reset = 1;
    #1;
    chk(mem_load === 1'b0, "reset_load_drop", {31'd0, mem_load}, 0);
    chk({busy, done, rd_valid, wr_ready, mem_load, mem_addr,
         mem_wdata, rd_data} == '0, "reset_mid_outputs",
        {busy, done, rd_valid, wr_ready, mem_load, mem_addr}, 0);
    cyc();
    wr_valid = 0;
    wr_data = 0;
    chk(ram[2] == 16'h1002, "reset_ram_kept", {16'd0, ram[2]}, 16'h1002);
    reset = 0;
    cyc();

    // write burst with wrap
    do_write(3'd6, 4'd4, 16'hA000);
    chk({ram[6], ram[7]} == {16'hA000, 16'hA001}, "ram_67",
        {ram[6], ram[7]}, {16'hA000, 16'hA001});
    chk({ram[0], ram[1]} == {16'hA002, 16'hA003}, "ram_01",
        {ram[0], ram[1]}, {16'hA002, 16'hA003});

    // read back with backpressure
    rq.push_back(16'hA000); rq.push_back(16'hA001);
    rq.push_back(16'hA002); rq.push_back(16'hA003);
    do_read(3'd6, 4'd4, 1, 0);

    // zero-length burst
    dir = 0; base = 5; count = 0; start = 1;
    cyc();
    start = 0;
    chk(done === 1'b1 && busy === 1'b1, "zero_done",
        {30'd0, done, busy}, 3);
    chk({rd_valid, wr_ready, mem_load} == 3'b000, "zero_no_access",
        {29'd0, rd_valid, wr_ready, mem_load}, 0);
    cyc();
    chk(done === 1'b0 && busy === 1'b0, "zero_idle",
        {30'd0, done, busy}, 0);

    // full wrap write then read
    do_write(3'd3, 4'd8, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = 16'((i + 5) % 8);
      chk(ram[i] == e, "wrap_ram", {16'(i), ram[i]}, {16'(i), e});
      rq.push_back(e);
    end
    do_read(3'd0, 4'd8, 0, 0);

    // start while busy is ignored
    rq.push_back(16'h0005); rq.push_back(16'h0006);
    do_read(3'd0, 4'd2, 1, 1);
    cyc();
    chk(busy === 1'b0, "no_queued_start", {31'd0, busy}, 0);
    chk(ram[0] == 16'h0005 && ram[1] == 16'h0006, "ram_untouched",
        {ram[0], ram[1]}, {16'h0005, 16'h0006});

    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
